dma_bus_arbiter: RTL
====================

Name: dma_bus_arbiter

Overview:
- Round-robin arbiter sharing the single RAM bus between NUM_REQ masters: DMA read engine, DMA write engine, CPU and spare.
- Consumes each master's mem_request and drives its mem_grant.
- Enforces a per-owner burst limit so a burst-mode DMA cannot starve the CPU.
- Inserts one idle turnaround cycle between owners.

Parameters:
- NUM_REQ, 4, number of requesting masters; index 0 is the CPU.
- MAX_BURST, 16, maximum consecutive grant cycles before a forced handoff when another master is waiting; 0 means unlimited.
- ID_W, 2, width of grant_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_request  in  NUM_REQ  per-master bus request, level-sensitive.
- mem_grant  out  NUM_REQ  one-hot grant, registered.
- grant_valid  out  1  OR of mem_grant, registered.
- grant_id  out  ID_W  index of the current owner; holds the last owner when grant_valid=0.
- forced_release  out  1  one-cycle pulse when an owner loses the bus due to the burst limit.

Behaviour:
- Reset (async, reset=1):
  - mem_grant=0, grant_valid=0, grant_id=0, forced_release=0.
  - State=IDLE, burst_cnt=0, last_owner=NUM_REQ-1, so master 0 has first priority.
- States: IDLE, GRANT, HANDOFF.
- Priority search always starts at (last_owner+1) mod NUM_REQ and takes the first set request bit.
- IDLE:
  - If any mem_request bit is set, register the winner's grant; state becomes GRANT and burst_cnt=0.
  - Latency: request seen at edge N, mem_grant high after edge N+1.
  - With no request, stay in IDLE.
- GRANT, each cycle:
  - burst_cnt increments, saturating at MAX_BURST.
  - If the owner's mem_request=0: go to HANDOFF and set last_owner=owner.
  - Else if MAX_BURST!=0, burst_cnt==MAX_BURST-1, and any other request is pending: go to HANDOFF, set last_owner=owner, pulse forced_release for one cycle.
  - Else if burst_cnt==MAX_BURST-1 and no other request is pending: reset burst_cnt to 0 and keep the grant.
  - Otherwise keep the grant unchanged.
- HANDOFF:
  - mem_grant=0 for exactly one cycle (bus turnaround).
  - Next cycle behaves like IDLE arbitration using the updated last_owner.
- Grant timing:
  - The gap between consecutive owners is exactly 1 cycle.
  - At most one grant bit is ever set.
  - The grant never changes in the same cycle a request changes; all outputs are registered.
- Simultaneous events:
  - Owner deassert and burst limit in the same cycle: treated as voluntary release; no forced_release.
  - Multiple new requests: round-robin order decides.
- A request that drops before it is granted is simply not granted; no memory of it is kept.
- Requests from masters outside 0..NUM_REQ-1 do not exist; the width is fixed by the parameter.
- Reset asserted mid-grant: grant drops asynchronously; no handoff cycle or pulse.

Optional Feature:
- Macro: ARB_CPU_PREEMPT_EN.
- Defined:
  - In GRANT with owner!=0, mem_request[0]=1 and owner held for at least 1 cycle: go to HANDOFF next edge and pulse forced_release.
  - The next arbitration grants master 0 regardless of the round-robin pointer.
  - last_owner stays unchanged, so the preempted master resumes its round-robin position.
- Undefined: master 0 waits for normal round-robin order or the burst limit, like any other master.

Decomposition:
- Shared package dma_pkg:
  - State encodings ST_IDLE=0, ST_GRANT=1, ST_HANDOFF=2.
  - Master index constants CPU_ID=0, DMA_RD_ID=1, DMA_WR_ID=2.
  - Default NUM_REQ and MAX_BURST values.
- Sub-module rr_pick: combinational rotate, priority-encode and unrotate.
  - Inputs: req vector, start index.
  - Outputs: winner index, found.
  - Reused by future channel schedulers.

Test Plan:
- Reset then mem_request=4'b0010 at edge 3 -> mem_grant=4'b0010 after edge 4, grant_id=1; request drops at edge 10 -> grant 0 for one cycle; nothing else pending, so state returns to IDLE.
- mem_request=4'b1111 held, MAX_BURST=4 -> owners 0,1,2,3,0 in turn, each held exactly 4 cycles, 1 idle cycle between; forced_release pulses at each switch.
- Master 1 sole requester for 40 cycles, MAX_BURST=16 -> continuous grant, no gaps, forced_release never pulses.
- Master 2 owns the bus, master 0 requests at cycle 5, ARB_CPU_PREEMPT_EN defined -> grant to 0 two edges later with one idle cycle; master 2 regranted afterwards.
- Same stimulus with the macro undefined -> master 0 waits until master 2 releases or its burst limit is hit.
- reset asserted mid-grant -> mem_grant=0 immediately, before the next clock edge; after release, a master 0 request wins first.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA bus arbiter: FSM encodings, master indices
// and default sizing.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HANDOFF = 2'd2
    } arb_state_t;

    localparam int CPU_ID    = 0;
    localparam int DMA_RD_ID = 1;
    localparam int DMA_WR_ID = 2;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_ID_W      = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so 'start' sits
// at bit 0, priority-encode the lowest set bit, then map it back to an index.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic [ID_W-1:0] winner,
    output logic            found
);

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [ID_W-1:0] offset;
    logic [ID_W:0]   sum;

    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> start);
    assign found   = |req;

    always_comb begin
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = ID_W'(i);
            end
        end
    end

    // The extra sum bit keeps the wrap-around test exact for any N.
    always_comb begin
        sum = {1'b0, offset} + {1'b0, start};
        if (sum >= (ID_W + 1)'(N)) begin
            sum = sum - (ID_W + 1)'(N);
        end
        winner = sum[ID_W-1:0];
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin RAM bus arbiter with per-owner burst limit and a one-cycle
// turnaround between owners. Optional CPU preemption: ARB_CPU_PREEMPT_EN.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int ID_W      = DEF_ID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] mem_request,
    output logic [NUM_REQ-1:0] mem_grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               forced_release
);

    localparam int              CNT_W      = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam bit              BURST_EN   = (MAX_BURST != 0);
    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_EN ? MAX_BURST - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_IDX   = ID_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]    last_owner_q, last_owner_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               forced_q, forced_d;
    logic               grant_valid_q;

    logic [ID_W-1:0]    rr_start;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    arb_id;
    logic               pick_found;
    logic               owner_req;
    logic               others_pending;
    logic               track_owner;

`ifdef ARB_CPU_PREEMPT_EN
    logic preempt_pend_q, preempt_pend_d;
    logic preempt_grant_q, preempt_grant_d;
`endif

    assign rr_start       = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + 1'b1;
    assign owner_req      = |(mem_request & grant_q);
    assign others_pending = |(mem_request & ~grant_q);

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (mem_request),
        .start  (rr_start),
        .winner (pick_id),
        .found  (pick_found)
    );

    // A grant won through CPU preemption does not advance the pointer, so the
    // preempted master gets its turn back afterwards.
    always_comb begin
        track_owner = 1'b1;
`ifdef ARB_CPU_PREEMPT_EN
        track_owner = !preempt_grant_q;
`endif
    end

    always_comb begin
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        forced_d     = 1'b0;
        arb_id       = pick_id;
`ifdef ARB_CPU_PREEMPT_EN
        preempt_pend_d  = preempt_pend_q;
        preempt_grant_d = preempt_grant_q;
`endif

        case (state_q)
            ST_IDLE, ST_HANDOFF: begin
`ifdef ARB_CPU_PREEMPT_EN
                preempt_pend_d  = 1'b0;
                preempt_grant_d = 1'b0;
                if (preempt_pend_q && mem_request[CPU_ID]) begin
                    arb_id          = ID_W'(CPU_ID);
                    preempt_grant_d = 1'b1;
                end
`endif
                if (pick_found) begin
                    grant_d     = NUM_REQ'(1) << arb_id;
                    owner_d     = arb_id;
                    burst_cnt_d = '0;
                    state_d     = ST_GRANT;
                end else begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (burst_cnt_q != BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Voluntary release wins over every forced reason.
                if (!owner_req) begin
                    state_d = ST_HANDOFF;
                    grant_d = '0;
                    if (track_owner) begin
                        last_owner_d = owner_q;
                    end
                end
`ifdef ARB_CPU_PREEMPT_EN
                else if (owner_q != ID_W'(CPU_ID) && mem_request[CPU_ID]) begin
                    state_d        = ST_HANDOFF;
                    grant_d        = '0;
                    forced_d       = 1'b1;
                    preempt_pend_d = 1'b1;
                end
`endif
                else if (BURST_EN && burst_cnt_q == BURST_LAST && others_pending) begin
                    state_d  = ST_HANDOFF;
                    grant_d  = '0;
                    forced_d = 1'b1;
                    if (track_owner) begin
                        last_owner_d = owner_q;
                    end
                end else if (BURST_EN && burst_cnt_q == BURST_LAST) begin
                    burst_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            burst_cnt_q   <= '0;
            last_owner_q  <= LAST_IDX;
            owner_q       <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            forced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            last_owner_q  <= last_owner_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            forced_q      <= forced_d;
        end
    end

`ifdef ARB_CPU_PREEMPT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preempt_pend_q  <= 1'b0;
            preempt_grant_q <= 1'b0;
        end else begin
            preempt_pend_q  <= preempt_pend_d;
            preempt_grant_q <= preempt_grant_d;
        end
    end
`endif

    assign mem_grant      = grant_q;
    assign grant_valid    = grant_valid_q;
    assign grant_id       = owner_q;
    assign forced_release = forced_q;

endmodule
